// File: rtl/y86_pkg.sv
// ============================================================================
// Module : y86_pkg
// Brief  : Shared Y86 definitions: imem load-FSM encoding, fetch window size
//          and instruction icodes used by both imem and fetch.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package y86_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_LOAD = 2'd1,
        IMEM_DONE = 2'd2,
        IMEM_ERR  = 2'd3
    } imem_state_t;

    localparam int INST_BYTES = 10;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

`default_nettype wire

// File: rtl/y86_imem_ldfsm.sv
// ============================================================================
// Module : y86_imem_ldfsm
// Brief  : Program-load state machine: write pointer, overflow flag, checksum
//          and write strobes toward the instruction array.
//          Optional feature macro: IMEM_CSUM_EN (running XOR checksum).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module y86_imem_ldfsm
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_start,
    input  logic [63:0]   ld_base,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          ld_error,
    output logic [7:0]    ld_csum,
    output logic          cpu_hold,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);

    imem_state_t state_q, state_d;
    logic [63:0] wp_q, wp_d;
    logic        error_q, error_d;
    logic        w_restart;
    logic        w_oob;

    // Start is only honoured when no session is in flight.
    assign w_restart = ld_start && ((state_q == IMEM_IDLE) || (state_q == IMEM_ERR));
    assign w_oob     = (wp_q >= 64'(MEM_BYTES));

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        error_d = error_q;
        wr_en   = 1'b0;
        case (state_q)
            IMEM_IDLE, IMEM_ERR: begin
                if (w_restart) begin
                    state_d = IMEM_LOAD;
                    wp_d    = ld_base;
                    error_d = 1'b0;
                end
            end
            IMEM_LOAD: begin
                if (ld_valid) begin
                    // Overflow wins over ld_last; the offending byte is dropped.
                    if (w_oob) begin
                        error_d = 1'b1;
                        state_d = IMEM_ERR;
                    end else begin
                        wr_en = 1'b1;
                        wp_d  = wp_q + 64'd1;
                        if (ld_last) begin
                            state_d = IMEM_DONE;
                        end
                    end
                end
            end
            IMEM_DONE: begin
                state_d = IMEM_IDLE;
            end
            default: begin
                state_d = IMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IMEM_IDLE;
            wp_q    <= 64'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            error_q <= error_d;
        end
    end

`ifdef IMEM_CSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (w_restart) begin
            csum_d = 8'h00;
        end else if (wr_en) begin
            csum_d = csum_q ^ ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign ld_csum = csum_q;
`else
    assign ld_csum = 8'h00;
`endif

    assign ld_ready = (state_q == IMEM_LOAD);
    assign ld_done  = (state_q == IMEM_DONE);
    assign cpu_hold = (state_q != IMEM_IDLE);
    assign ld_error = error_q;
    assign wr_addr  = wp_q[AW-1:0];
    assign wr_data  = ld_data;

endmodule

`default_nettype wire

// File: rtl/y86_imem.sv
// ============================================================================
// Module : y86_imem
// Brief  : Byte-addressed Y86 instruction memory with streaming program-load
//          port and a combinational 10-byte fetch window.
//          Optional feature macro: IMEM_CSUM_EN (load checksum on ld_csum).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module y86_imem
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_start,
    input  logic [63:0] ld_base,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done,
    output logic        ld_error,
    output logic [7:0]  ld_csum,
    output logic        cpu_hold,
    input  logic [63:0] rd_pc,
    output logic [79:0] rd_bytes,
    output logic        rd_error
);

    localparam int AW = $clog2(MEM_BYTES);

    logic          w_wr_en;
    logic [AW-1:0] w_wr_addr;
    logic [7:0]    w_wr_data;
    logic [7:0]    mem [MEM_BYTES];

    y86_imem_ldfsm #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_ldfsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_start (ld_start),
        .ld_base  (ld_base),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_last  (ld_last),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_error (ld_error),
        .ld_csum  (ld_csum),
        .cpu_hold (cpu_hold),
        .wr_en    (w_wr_en),
        .wr_addr  (w_wr_addr),
        .wr_data  (w_wr_data)
    );

    // The array is deliberately left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[w_wr_addr] <= w_wr_data;
        end
    end

    assign rd_error = (rd_pc > 64'(MEM_BYTES - INST_BYTES));

    // In range, pc+9 never exceeds MEM_BYTES-1, so AW-bit offsets cannot wrap.
    for (genvar g = 0; g < INST_BYTES; g++) begin : g_rd_byte
        logic [AW-1:0] w_addr;
        assign w_addr             = rd_pc[AW-1:0] + AW'(g);
        assign rd_bytes[8*g +: 8] = rd_error ? 8'h00 : mem[w_addr];
    end

endmodule

`default_nettype wire

// File: tb/tb_y86_imem.sv
// ============================================================================
// Module : tb_y86_imem
// Brief  : Self-checking bench for y86_imem against a byte-array load model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_y86_imem;

    localparam int MEM = 1024;
`ifdef IMEM_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_start = 1'b0;
    logic [63:0] ld_base = '0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready, ld_done, ld_error, cpu_hold, rd_error;
    logic [7:0]  ld_csum;
    logic [63:0] rd_pc = '0;
    logic [79:0] rd_bytes;

    y86_imem #(.MEM_BYTES(MEM)) dut (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_base(ld_base),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_error(ld_error),
        .ld_csum(ld_csum), .cpu_hold(cpu_hold), .rd_pc(rd_pc),
        .rd_bytes(rd_bytes), .rd_error(rd_error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain byte array plus session bookkeeping.
    logic [7:0]  ref_mem [MEM];
    logic [63:0] m_wp = '0;
    logic [7:0]  m_csum = '0;
    bit          m_err = 1'b0;
    bit          m_active = 1'b0;
    int          hold_bad = 0;
    logic        last_ready = 1'b0;

    function automatic logic [79:0] exp_read(input logic [63:0] pc);
        logic [79:0] r = '0;
        if (pc <= 64'(MEM - 10)) begin
            for (int i = 0; i < 10; i++) r[8*i +: 8] = ref_mem[int'(pc) + i];
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_csum();
        return CSUM_EN ? m_csum : 8'h00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [63:0] base);
        ld_start = 1'b1;
        ld_base  = base;
        tick();
        ld_start = 1'b0;
        if (!m_active) begin
            m_active = 1'b1;
            m_wp     = base;
            m_csum   = 8'h00;
            m_err    = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input int gap);
        ld_valid = 1'b0;
        repeat (gap) begin
            tick();
            if (m_active && cpu_hold !== 1'b1) hold_bad++;
        end
        ld_valid   = 1'b1;
        ld_data    = d;
        ld_last    = last;
        last_ready = ld_ready;
        if (m_active && cpu_hold !== 1'b1) hold_bad++;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (m_active) begin
            if (m_wp >= 64'(MEM)) begin
                m_err    = 1'b1;
                m_active = 1'b0;
            end else begin
                ref_mem[int'(m_wp)] = d;
                m_wp   = m_wp + 64'd1;
                m_csum = m_csum ^ d;
                if (last) m_active = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ld_ready); end
        n_vec++; if (ld_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", ld_done); end
        n_vec++; if (ld_error !== 1'b0) begin n_err++; $display("FAIL reset_error got=%b exp=0", ld_error); end
        n_vec++; if (ld_csum !== 8'h00) begin n_err++; $display("FAIL reset_csum got=%h exp=00", ld_csum); end
        n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL reset_hold got=%b exp=0", cpu_hold); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        start_load(64'd0);
        for (int i = 0; i < MEM; i++)
            send_byte(8'($urandom), i == MEM - 1, ($urandom_range(0, 7) == 0) ? 1 : 0);
        n_vec++; if (ld_done !== 1'b1) begin n_err++; $display("FAIL fill_done got=%b exp=1", ld_done); end
        tick();
        n_vec++; if (ld_done !== 1'b0) begin n_err++; $display("FAIL fill_done_pulse got=%b exp=0", ld_done); end
        n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL fill_hold got=%b exp=0", cpu_hold); end
        n_vec++; if (ld_error !== 1'b0) begin n_err++; $display("FAIL fill_error got=%b exp=0", ld_error); end
        n_vec++; if (ld_csum !== exp_csum()) begin n_err++; $display("FAIL fill_csum got=%h exp=%h", ld_csum, exp_csum()); end
        for (int k = 0; k < 30; k++) begin
            rd_pc = 64'($urandom_range(0, MEM - 10));
            @(negedge clk);
            n_vec++; if (rd_bytes !== exp_read(rd_pc) || rd_error !== 1'b0) begin
                n_err++; $display("FAIL fill_read pc=%0d got=%h/%b exp=%h/0", rd_pc, rd_bytes, rd_error, exp_read(rd_pc));
            end
        end
    endtask

    task automatic test_clean_load();
        logic [7:0] prog [10];
        prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        start_load(64'd0);
        n_vec++; if (ld_ready !== 1'b1 || cpu_hold !== 1'b1) begin
            n_err++; $display("FAIL clean_ready got=%b/%b exp=1/1", ld_ready, cpu_hold);
        end
        for (int i = 0; i < 10; i++) send_byte(prog[i], i == 9, 0);
        n_vec++; if (ld_done !== 1'b1 || cpu_hold !== 1'b1) begin
            n_err++; $display("FAIL clean_done got=%b/%b exp=1/1", ld_done, cpu_hold);
        end
        tick();
        n_vec++; if (ld_done !== 1'b0 || cpu_hold !== 1'b0) begin
            n_err++; $display("FAIL clean_idle got=%b/%b exp=0/0", ld_done, cpu_hold);
        end
        rd_pc = 64'd0;
        @(negedge clk);
        n_vec++; if (rd_bytes[15:0] !== 16'hF230 || rd_bytes[23:16] !== 8'h0A) begin
            n_err++; $display("FAIL clean_bytes got=%h exp=0af230", rd_bytes[23:0]);
        end
        n_vec++; if (rd_bytes !== exp_read(64'd0) || rd_error !== 1'b0) begin
            n_err++; $display("FAIL clean_window got=%h/%b exp=%h/0", rd_bytes, rd_error, exp_read(64'd0));
        end
        n_vec++; if (ld_csum !== (CSUM_EN ? 8'hC8 : 8'h00)) begin
            n_err++; $display("FAIL clean_csum got=%h exp=%h", ld_csum, CSUM_EN ? 8'hC8 : 8'h00);
        end
    endtask

    task automatic test_gaps();
        hold_bad = 0;
        start_load(64'd20);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), i == 2, (i == 0) ? 0 : 3);
        n_vec++; if (hold_bad !== 0) begin n_err++; $display("FAIL gaps_hold got=%0d drops exp=0", hold_bad); end
        n_vec++; if (m_wp !== 64'd23 || ld_done !== 1'b1) begin
            n_err++; $display("FAIL gaps_done got=%b exp=1 (model wp=%0d)", ld_done, m_wp);
        end
        tick();
        rd_pc = 64'd16;
        @(negedge clk);
        n_vec++; if (rd_bytes !== exp_read(64'd16)) begin
            n_err++; $display("FAIL gaps_mem got=%h exp=%h", rd_bytes, exp_read(64'd16));
        end
    endtask

    task automatic test_overflow();
        start_load(64'd1022);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 0);
        n_vec++; if (ld_error !== 1'b1 || ld_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            n_err++; $display("FAIL ovf_flags got=err%b rdy%b hold%b exp=1/0/1", ld_error, ld_ready, cpu_hold);
        end
        n_vec++; if (ld_csum !== exp_csum()) begin n_err++; $display("FAIL ovf_csum got=%h exp=%h", ld_csum, exp_csum()); end
        send_byte(8'($urandom), 1'b1, 0);
        n_vec++; if (last_ready !== 1'b0 || ld_done !== 1'b0 || ld_error !== 1'b1) begin
            n_err++; $display("FAIL ovf_err_state got=rdy%b done%b err%b exp=0/0/1", last_ready, ld_done, ld_error);
        end
        rd_pc = 64'd1014;
        @(negedge clk);
        n_vec++; if (rd_bytes !== exp_read(64'd1014)) begin
            n_err++; $display("FAIL ovf_mem got=%h exp=%h", rd_bytes, exp_read(64'd1014));
        end
        start_load(64'd5000);
        n_vec++; if (ld_error !== 1'b0 || ld_ready !== 1'b1 || ld_csum !== 8'h00) begin
            n_err++; $display("FAIL ovf_restart got=err%b rdy%b csum%h exp=0/1/00", ld_error, ld_ready, ld_csum);
        end
        send_byte(8'($urandom), 1'b1, 0);
        n_vec++; if (ld_error !== 1'b1 || ld_done !== 1'b0) begin
            n_err++; $display("FAIL ovf_base_high got=err%b done%b exp=1/0", ld_error, ld_done);
        end
        start_load(64'hFFFF_FFFF_FFFF_FFFF);
        send_byte(8'($urandom), 1'b0, 0);
        n_vec++; if (ld_error !== 1'b1 || ld_ready !== 1'b0) begin
            n_err++; $display("FAIL ovf_base_max got=err%b rdy%b exp=1/0", ld_error, ld_ready);
        end
        start_load(64'd600);
        send_byte(8'($urandom), 1'b1, 0);
        n_vec++; if (ld_done !== 1'b1 || ld_error !== 1'b0) begin
            n_err++; $display("FAIL ovf_recover got=done%b err%b exp=1/0", ld_done, ld_error);
        end
        tick();
    endtask

    task automatic test_read_bounds();
        logic [63:0] pcs [5];
        pcs = '{64'd1014, 64'd1015, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA, 64'h1_0000_0000};
        for (int i = 0; i < 5; i++) begin
            rd_pc = pcs[i];
            @(negedge clk);
            n_vec++; if (rd_error !== (pcs[i] > 64'(MEM - 10)) || rd_bytes !== exp_read(pcs[i])) begin
                n_err++; $display("FAIL bounds pc=%h got=%b/%h exp=%b/%h", pcs[i], rd_error, rd_bytes,
                                  pcs[i] > 64'(MEM - 10), exp_read(pcs[i]));
            end
        end
        for (int k = 0; k < 20; k++) begin
            rd_pc = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(1000, 1030)) : {32'($urandom), 32'($urandom)};
            @(negedge clk);
            n_vec++; if (rd_error !== (rd_pc > 64'(MEM - 10)) || rd_bytes !== exp_read(rd_pc)) begin
                n_err++; $display("FAIL bounds_rand pc=%h got=%b/%h exp=%h", rd_pc, rd_error, rd_bytes, exp_read(rd_pc));
            end
        end
    endtask

    task automatic test_reset_midload();
        start_load(64'd100);
        send_byte(8'($urandom), 1'b0, 0);
        start_load(64'd500);
        send_byte(8'($urandom), 1'b0, 0);
        n_vec++; if (m_wp !== 64'd102 || ld_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_in_load got=rdy%b exp=1", ld_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        m_active = 1'b0;
        m_csum   = 8'h00;
        m_err    = 1'b0;
        n_vec++; if (cpu_hold !== 1'b0 || ld_ready !== 1'b0 || ld_csum !== 8'h00) begin
            n_err++; $display("FAIL mid_async got=hold%b rdy%b csum%h exp=0/0/00", cpu_hold, ld_ready, ld_csum);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        rd_pc = 64'd96;
        @(negedge clk);
        n_vec++; if (rd_bytes !== exp_read(64'd96)) begin
            n_err++; $display("FAIL mid_kept got=%h exp=%h", rd_bytes, exp_read(64'd96));
        end
        rd_pc = 64'd496;
        @(negedge clk);
        n_vec++; if (rd_bytes !== exp_read(64'd496)) begin
            n_err++; $display("FAIL mid_ignored_start got=%h exp=%h", rd_bytes, exp_read(64'd496));
        end
    endtask

    task automatic test_random_loads();
        logic [63:0] base, pc;
        int len;
        for (int s = 0; s < 10; s++) begin
            base = 64'($urandom_range(0, MEM + 4));
            len  = $urandom_range(1, 12);
            start_load(base);
            for (int i = 0; i < len; i++) send_byte(8'($urandom), i == len - 1, $urandom_range(0, 2));
            if (m_err) begin
                n_vec++; if (ld_error !== 1'b1 || ld_ready !== 1'b0) begin
                    n_err++; $display("FAIL rand_err s=%0d got=err%b rdy%b exp=1/0", s, ld_error, ld_ready);
                end
                n_vec++; if (ld_csum !== exp_csum()) begin
                    n_err++; $display("FAIL rand_err_csum s=%0d got=%h exp=%h", s, ld_csum, exp_csum());
                end
                start_load(64'd0);
                send_byte(8'($urandom), 1'b1, 0);
            end else begin
                n_vec++; if (ld_done !== 1'b1 || ld_error !== 1'b0) begin
                    n_err++; $display("FAIL rand_done s=%0d got=done%b err%b exp=1/0", s, ld_done, ld_error);
                end
            end
            tick();
            n_vec++; if (cpu_hold !== 1'b0 || ld_csum !== exp_csum()) begin
                n_err++; $display("FAIL rand_end s=%0d got=hold%b csum%h exp=0/%h", s, cpu_hold, ld_csum, exp_csum());
            end
            pc = (base > 64'(MEM - 10)) ? 64'(MEM - 10) : base;
            rd_pc = pc;
            @(negedge clk);
            n_vec++; if (rd_bytes !== exp_read(pc)) begin
                n_err++; $display("FAIL rand_mem s=%0d pc=%0d got=%h exp=%h", s, pc, rd_bytes, exp_read(pc));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_clean_load();
        test_gaps();
        test_overflow();
        test_read_bounds();
        test_reset_midload();
        test_random_loads();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/y86_imem.md
# y86_imem

Byte-addressed Y86 instruction memory with a program-load port. A loader streams bytes in over a valid/ready handshake, managed by a load state machine, and fetch reads a 10-byte instruction window at any PC. Sits between the program loader and the fetch stage. Holds the pipeline (`cpu_hold`) while a load is in progress.

## Interface
- `MEM_BYTES`, default 1024: memory size in bytes, at least 10.
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ld_start` in 1: one-cycle pulse that starts a load session.
- `ld_base` in 64: first write address, sampled on `ld_start`.
- `ld_valid` in 1: loader byte valid.
- `ld_data` in 8: loader byte.
- `ld_last` in 1: marks the final byte of the session.
- `ld_ready` out 1: memory accepts a byte.
- `ld_done` out 1: one-cycle pulse when the session completes cleanly.
- `ld_error` out 1: sticky address-overflow flag.
- `ld_csum` out 8: running XOR of the accepted bytes.
- `cpu_hold` out 1: fetch must stall.
- `rd_pc` in 64: fetch PC.
- `rd_bytes` out 80: bytes pc..pc+9. `[7:0]`=mem[pc], where `[7:4]` is icode and `[3:0]` is ifun; `[79:72]`=mem[pc+9].
- `rd_error` out 1: instruction-memory error.

## Operation
- **States:** IDLE, LOAD, DONE, ERR. Reset drives IDLE.
- **IDLE:**
  - `ld_start` → LOAD.
  - The write pointer `wp` loads `ld_base`.
  - `ld_csum` clears to 0 and `ld_error` clears to 0.
- **LOAD:**
  - `ld_ready`=1 and `cpu_hold`=1.
  - A byte transfers on a rising edge with `ld_valid && ld_ready`: mem[wp] ← `ld_data`, `wp` ← `wp`+1, and `ld_csum` ^= `ld_data`.
  - A transfer with `ld_last`=1 moves the FSM to DONE.
  - A transfer with `wp` ≥ `MEM_BYTES` discards the byte (no write, no checksum update), sets `ld_error`, and moves the FSM to ERR. This check takes priority over `ld_last`.
  - `ld_start` is ignored while in LOAD.
- **DONE:** `ld_done`=1 for exactly one cycle, `cpu_hold`=1, then IDLE.
- **ERR:**
  - `ld_ready`=0 and `cpu_hold`=1.
  - The FSM stays in ERR until `ld_start`, which behaves as in IDLE.
- **Outputs by state:** `cpu_hold`=0 only in IDLE. `ld_ready`=1 only in LOAD.
- **Write pointer width:**
  - `wp` is 64-bit.
  - `ld_base` ≥ `MEM_BYTES` errors on the first byte.
  - `wp` wrap from 2^64−1 to 0 counts as overflow and errors.
- **Read port (combinational):**
  - `rd_error`=1 when `rd_pc` > `MEM_BYTES`−10, using unsigned 64-bit compare with no wrap.
  - With `rd_error`=1, `rd_bytes`=0.
  - Otherwise `rd_bytes` reflects the current memory contents.
- **Read during load:** a read of an address written on the same edge returns the old byte before the edge and the new byte after it.

## Timing
- **Reset values:**
  - state=IDLE, `wp`=0.
  - `ld_ready`=0, `ld_done`=0, `ld_error`=0, `ld_csum`=0, `cpu_hold`=0.
  - Memory array is not reset.
- **State changes:**
  - `ld_start` at edge N → `ld_ready`=1 from N+1.
  - Last byte accepted at edge M → `ld_done` is high during cycle M+1 → IDLE and `cpu_hold`=0 from M+2.
- **Throughput:** one byte per cycle. The loader may hold `ld_valid` low for any number of cycles.
- **Mid-operation reset:**
  - Reset mid-load returns the FSM to IDLE immediately and asynchronously.
  - Bytes already written remain in memory.
  - Memory writes are synchronous only.
- **Read latency:** zero cycles from `rd_pc` to `rd_bytes`/`rd_error`.

## Configuration
- **`IMEM_CSUM_EN` defined:** `ld_csum` is the running XOR as specified above.
- **`IMEM_CSUM_EN` undefined:** `ld_csum` is tied to 0 and no checksum register exists. Port list is unchanged.

## Structure
- **Shared package `y86_pkg`:**
  - Load-FSM state encoding `imem_state_t`.
  - `INST_BYTES`=10.
  - Icode constants, shared with fetch.
- **Sub-module `y86_imem_ldfsm`:** the state machine, `wp`, `ld_error` and `ld_csum`. It emits write-enable/address/data signals to the array, which stays in the top module.

## Test plan
- **Clean load:** `ld_start` with `ld_base`=0, then bytes 0x30,0xF2,0x0A,0,0,0,0,0,0,0 with `ld_last` on the 10th → `ld_done` pulses once. Then `rd_pc`=0 gives `rd_bytes`[15:0]=0xF230 and [23:16]=0x0A; `rd_error`=0; `ld_csum`=0x30^0xF2^0x0A=0xC8.
- **Backpressure gaps:** bytes at 20..22 with `ld_valid` low 3 cycles between each → exactly 3 writes, `wp`=23, `cpu_hold`=1 throughout the session.
- **Overflow:** `ld_base`=1022 (1024-byte memory), 4 bytes → bytes written at 1022 and 1023, 3rd byte discarded, `ld_error`=1, state ERR, `ld_ready`=0. A new `ld_start` clears `ld_error`.
- **Read bounds:** `rd_pc`=1014 → `rd_error`=0. `rd_pc`=1015 → `rd_error`=1, `rd_bytes`=0. `rd_pc`=2^64−1 → `rd_error`=1.
- **Reset mid-load:** deassert `rst_n` after 2 of 5 bytes → IDLE, `cpu_hold`=0, the 2 bytes remain readable. `ld_start` ignored while in LOAD.
- **Checksum macro:** without `IMEM_CSUM_EN`, repeat the clean-load scenario → `ld_csum`=0 and all other results unchanged.
